// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
//
// Purpose:
//   Keeps the running game score and the best score as two-digit BCD values
//   and time-multiplexes them onto a 4-digit common-anode 7-segment display.
//   Digit 0/1 show the current score (ones/tens) and digit 2/3 show the best
//   score (ones/tens). A leading zero in either tens position is blanked, and
//   the decimal point on digit 2 separates the two numbers visually.
//
// Optional feature (macro SCORE_DISPLAY_HIGH_SCORE_EN):
//   Defined   : best-score tracking, digits 2/3 and the separator dot are live.
//   Undefined : high_bcd is tied to 8'h00, an[3:2] stay high, the dot is
//               always off and only digits 0/1 are scanned.
//
// Parameters:
//   SCAN_BITS   - each digit is lit for 2^SCAN_BITS clocks.
//
// Ports:
//   Clk         in   1  single clock, all registers rising-edge
//   reset_n     in   1  asynchronous active-low reset
//   score_pulse in   1  one-cycle pulse when a pipe is cleared
//   lose        in   1  level, high while the game is in the lose state
//   clear       in   1  one-cycle pulse when a new game starts
//   score_bcd   out  8  current score {tens, ones}
//   high_bcd    out  8  best score {tens, ones}
//   an          out  4  active-low anode enables
//   seg         out  8  active-low cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
// ---------------------------------------------------------------------------
module score_display #(
  parameter int SCAN_BITS = 18
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       score_pulse,
  input  logic       lose,
  input  logic       clear,
  output logic [7:0] score_bcd,
  output logic [7:0] high_bcd,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int CNT_W = SCAN_BITS + 2;

  logic [CNT_W-1:0] scan_cnt;
  logic             lose_q;
  logic [7:0]       score_inc;
  logic [1:0]       digit_sel;
  logic [3:0]       digit_val;
  logic             digit_blank;
  logic             dp_n;
  logic [6:0]       seg_pat;
  logic [3:0]       an_next;
  logic [7:0]       seg_next;

  // Decimal +1 on the BCD score: a ones digit of 9 rolls to 0 and carries.
  // Saturation at 99 is handled where the register is loaded.
  always_comb begin
    score_inc = score_bcd;
    if (score_bcd[3:0] == 4'd9) begin
      score_inc = {score_bcd[7:4] + 4'd1, 4'd0};
    end else begin
      score_inc = {score_bcd[7:4], score_bcd[3:0] + 4'd1};
    end
  end

  // Current score. A new-game clear wins over a pipe pulse in the same
  // cycle; pulses are ignored while the game is lost or already at 99.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd <= 8'h00;
    end else if (clear) begin
      score_bcd <= 8'h00;
    end else if (score_pulse && !lose && (score_bcd != 8'h99)) begin
      score_bcd <= score_inc;
    end
  end

  // Delayed copy of lose, used to spot the cycle the game is lost.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      lose_q <= 1'b0;
    end else begin
      lose_q <= lose;
    end
  end

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  logic lose_rise;

  assign lose_rise = lose & ~lose_q;

  // Best score. Compared against score_bcd as it stands before this edge,
  // so a clear arriving together with the lose event cannot hide the
  // finished game's score. Valid BCD orders the same as its binary value,
  // so a plain unsigned compare is enough. Only reset ever lowers it.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      high_bcd <= 8'h00;
    end else if (lose_rise && (score_bcd > high_bcd)) begin
      high_bcd <= score_bcd;
    end
  end

  // All four digits are scanned: the top two counter bits pick the digit.
  assign digit_sel = scan_cnt[CNT_W-1 -: 2];
`else
  logic [1:0] unused_bits;

  assign high_bcd = 8'h00;

  // Only the score digits are scanned, so the upper select bit is forced to
  // zero and the lower one alternates between digit 0 and digit 1.
  assign digit_sel   = {1'b0, scan_cnt[CNT_W-2]};
  assign unused_bits = {scan_cnt[CNT_W-1], lose_q};
`endif

  // Free-running scan counter; wraps naturally so the digit order repeats.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Pick the nibble for the selected digit, whether it is a blanked leading
  // zero, and whether the separator dot belongs on it.
  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    dp_n        = 1'b1;
    case (digit_sel)
      2'd0: begin
        digit_val = score_bcd[3:0];
      end
      2'd1: begin
        digit_val   = score_bcd[7:4];
        digit_blank = (score_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        digit_val = high_bcd[3:0];
        dp_n      = 1'b0;
      end
      default: begin
        digit_val   = high_bcd[7:4];
        digit_blank = (high_bcd[7:4] == 4'd0);
      end
    endcase
  end

  // Active-low segment patterns {a,b,c,d,e,f,g}. Anything that is not a
  // decimal digit lights nothing, as does a blanked digit.
  always_comb begin
    seg_pat = 7'b1111111;
    case (digit_val)
      4'd0:    seg_pat = 7'b0000001;
      4'd1:    seg_pat = 7'b1001111;
      4'd2:    seg_pat = 7'b0010010;
      4'd3:    seg_pat = 7'b0000110;
      4'd4:    seg_pat = 7'b1001100;
      4'd5:    seg_pat = 7'b0100100;
      4'd6:    seg_pat = 7'b0100000;
      4'd7:    seg_pat = 7'b0001111;
      4'd8:    seg_pat = 7'b0000000;
      4'd9:    seg_pat = 7'b0000100;
      default: seg_pat = 7'b1111111;
    endcase
    if (digit_blank) begin
      seg_pat = 7'b1111111;
    end
  end

  // One-hot low anode for the selected digit.
  assign an_next  = ~(4'b0001 << digit_sel);
  assign seg_next = {seg_pat, dp_n};

  // Registered display drive: glitch-free pins, one clock behind the select.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// ---------------------------------------------------------------------------
// tb_score_display
//
// Scoreboard bench for score_display with SCAN_BITS=2 (4-clock dwell).
// Every stimulus cycle runs a behavioural game model (integer scores, best
// score, edge count since reset) and pushes the expected post-edge outputs
// into a queue; a separate monitor pops one entry after each clock edge and
// compares. Honours SCORE_DISPLAY_HIGH_SCORE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_score_display;

  localparam int SCAN_BITS = 2;
  localparam int DWELL     = 1 << SCAN_BITS;

  logic       clk         = 1'b0;
  logic       reset_n     = 1'b1;
  logic       score_pulse = 1'b0;
  logic       lose        = 1'b0;
  logic       clear       = 1'b0;
  logic [7:0] score_bcd;
  logic [7:0] high_bcd;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] score;
    logic [7:0] high;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int m_score  = 0;
  int m_high   = 0;
  int m_edges  = 0;
  bit m_lose_q = 1'b0;
  bit lose_lvl = 1'b0;

  score_display #(
    .SCAN_BITS(SCAN_BITS)
  ) dut (
    .Clk        (clk),
    .reset_n    (reset_n),
    .score_pulse(score_pulse),
    .lose       (lose),
    .clear      (clear),
    .score_bcd  (score_bcd),
    .high_bcd   (high_bcd),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  // Standard active-low 7-segment table {a..g}.
  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Game model for one clock edge: display is built from the values held
  // before the edge, then the score/best score rules are applied.
  task automatic model_edge(input bit sp, input bit ls, input bit cl);
    exp_t e;
    int   dig;
    int   v;
    bit   blank;
`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    dig = (m_edges / DWELL) % 4;
`else
    dig = (m_edges / DWELL) % 2;
`endif
    blank = 1'b0;
    case (dig)
      0:       v = m_score % 10;
      1:       begin v = m_score / 10; blank = (v == 0); end
      2:       v = m_high % 10;
      default: begin v = m_high / 10; blank = (v == 0); end
    endcase
    e.an      = 4'hF;
    e.an[dig] = 1'b0;
    e.seg     = {(blank ? 7'b1111111 : seg_of(v)), ((dig == 2) ? 1'b0 : 1'b1)};
`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    if (ls && !m_lose_q && (m_score > m_high)) m_high = m_score;
`endif
    if (cl) m_score = 0;
    else if (sp && !ls && (m_score < 99)) m_score = m_score + 1;
    m_lose_q = ls;
    m_edges  = m_edges + 1;
    e.score  = to_bcd(m_score);
    e.high   = to_bcd(m_high);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, record the expectation, advance one clock.
  task automatic applyStimulus(input bit sp, input bit ls, input bit cl);
    score_pulse = sp;
    lose        = ls;
    clear       = cl;
    model_edge(sp, ls, cl);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Asynchronous reset between edges; outputs must drop before any clock.
  task automatic applyReset();
    score_pulse = 1'b0;
    lose        = 1'b0;
    clear       = 1'b0;
    reset_n     = 1'b0;
    #1;
    checkOutput("rst_score", score_bcd, 8'h00);
    checkOutput("rst_high", high_bcd, 8'h00);
    checkOutput("rst_an", {4'h0, an}, 8'h0F);
    checkOutput("rst_seg", seg, 8'hFF);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_an", {4'h0, an}, 8'h0F);
    checkOutput("rst_hold_seg", seg, 8'hFF);
    #3;
    reset_n  = 1'b1;
    m_score  = 0;
    m_high   = 0;
    m_edges  = 0;
    m_lose_q = 1'b0;
  endtask

  // Monitor: one expected entry per active edge, compared just after it.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("score", score_bcd, mon_e.score);
      checkOutput("high", high_bcd, mon_e.high);
      checkOutput("an", {4'h0, an}, {4'h0, mon_e.an});
      checkOutput("seg", seg, mon_e.seg);
    end
  end

  initial begin
    #1;
    applyReset();
    idle(3);

    // Score 23 and let the display scan through every digit twice.
    pulses(23);
    idle(8 * DWELL);

    // Saturation at 99 and one more pulse.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses(105);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(4 * DWELL);

    // Best score 17, then a lower game must not replace it.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses(17);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle(4 * DWELL);

    // Clear beats a same-cycle pulse at 09; pulses ignored while lost.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses(9);
    applyStimulus(1'b1, 1'b0, 1'b1);
    pulses(4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Score 30 with clear and lose rising together: best score still sees 30.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses(30);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4 * DWELL; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset in the middle of a scan with score 42.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses(42);
    idle(5);
    applyReset();
    idle(2);
    checkOutput("an_after_rst", {4'h0, an}, 8'h0E);
    idle(4 * DWELL);

    // Random play.
    lose_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) lose_lvl = ~lose_lvl;
      applyStimulus(1'($urandom_range(0, 1)), lose_lvl,
                    ($urandom_range(0, 39) == 0));
    end
    idle(3);

    checkOutput("drain", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
